mul_sequencer: RTL and testbench
================================

# mul_sequencer

Multi-cycle 32x32 multiply controller that computes MULT/MULTU results into HI/LO by sequencing the shared 32-bit ALU through 32 shift-and-add iterations. It arbitrates for the ALU with a request/grant pair and stalls on any ungranted cycle. It sits beside the main datapath. The core starts it and waits on `done`, while the datapath owner grants the ALU in cycles where the datapath does not need it.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported; the step count equals `WIDTH`.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: request a multiply. Accepted only when `busy`=0.
- `is_signed` in 1: sampled with `start`. 1 = MULT (two's complement), 0 = MULTU.
- `src_a` in 32: multiplicand, sampled with `start`.
- `src_b` in 32: multiplier, sampled with `start`.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse. `hi`/`lo` are valid from this cycle.
- `hi` out 32: upper product word.
- `lo` out 32: lower product word.
- `alu_req` out 1: ALU wanted this cycle.
- `alu_gnt` in 1: ALU owned by this block this cycle. Ignored while `alu_req`=0.
- `alu_op_a` out 32: ALU operand A.
- `alu_op_b` out 32: ALU operand B.
- `alu_control` out 3: ALU function select.
- `alu_result` in 32: combinational ALU result for the current `alu_op_a`/`alu_op_b`.

## Operation
- **States:** IDLE, ITER, SIGN.
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, count=0, M=0, neg=0.
  - Combinational outputs are then `alu_req`=0, `alu_op_a`=0, `alu_op_b`=0, `alu_control`=3'b000.
- **IDLE + `start`:**
  - M = |`src_a`|; `lo` = |`src_b`|; `hi`=0; count=0.
  - neg = `is_signed` & (`src_a`[31] ^ `src_b`[31]).
  - Go to ITER.
  - Magnitudes apply only when `is_signed`=1; otherwise the raw values are used. |0x80000000| = 0x80000000 as an unsigned 32-bit value.
- **ITER outputs:**
  - `alu_req`=1, `alu_control`=ADD (3'b010).
  - `alu_op_a`=`hi`; `alu_op_b` = `lo`[0] ? M : 0.
- **ITER step** (on each edge with `alu_gnt`=1):
  - c = (A[31]&B[31]) | ((A[31]|B[31]) & ~`alu_result`[31]), with A/B = `alu_op_a`/`alu_op_b`.
  - {`hi`,`lo`} = {c, `alu_result`, `lo`} >> 1, keeping the low 64 bits.
  - count = count + 1.
  - After the step with count==31, go to SIGN.
- **ITER with `alu_gnt`=0:** all registers hold, `alu_req` stays 1, and no step is counted.
- **SIGN** (one cycle, ALU not used):
  - If neg, {`hi`,`lo`} = ~{`hi`,`lo`} + 1 (local 64-bit incrementer).
  - `done`=1 on the next cycle; go to IDLE.
- **Outside ITER:** `alu_req`=0; `alu_op_a`, `alu_op_b` and `alu_control` are driven 0.
- **`start` while `busy`=1:** ignored, no queueing.
- **`start` in the same cycle as `done`:** accepted, because the state is already IDLE. `hi`/`lo` are overwritten at that edge.
- **Result lifetime:** `hi`/`lo` hold the result from `done` until the next accepted `start`. Their contents during `busy` are not architecturally meaningful.
- **`RST` mid-operation:** immediate return to reset values. No `done` pulse is issued and the partial result is discarded.

## Timing
- **Zero-stall latency:**
  - `start` sampled at edge E0.
  - Steps at edges E1–E32.
  - SIGN at E33: `done`=1 and `hi`/`lo` valid in the cycle after E33.
- **With stalls:** latency = 33 cycles plus one cycle per ITER cycle with `alu_gnt`=0.
- **`busy`:** registered; 1 from after E0 through the SIGN cycle, 0 in the `done` cycle.
- **`done`:** registered, exactly one cycle wide.
- **ALU path:** combinational round-trip `hi` → `alu_op_a` → ALU → `alu_result` → carry/shift → `hi`, within one cycle.
- **`alu_req`:** a decode of registered state; no combinational dependence on `alu_gnt`.

## Structure
- **Shared header** (used by the control unit and by this block):
  - ALU function encodings: AND 000, OR 001, ADD 010, SUB 011, ANDN 100, ORN 101, SLT 110, XOR 111.
  - State encodings IDLE/ITER/SIGN.
  - `WIDTH`.
- **Sub-modules:** none required. A local `abs32` helper function/module for operand magnitude is acceptable. The 64-bit negate stays inline.
- **ALU ownership:** the ALU is not instantiated here. The owner muxes `alu_op_a`/`alu_op_b`/`alu_control` onto it when `alu_gnt`=1.

## Test plan
- **MULTU small:** 3 × 5 with `alu_gnt` tied 1 → `hi`=0x00000000, `lo`=0x0000000F. `done` 33 cycles after the start edge; `busy` drops with `done`.
- **MULTU carry path:** 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **MULT signs:**
  - −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
- **Grant stalls:** 7 × 9 with `alu_gnt` alternating 0/1 → `lo`=0x0000003F, `done` delayed by exactly the number of denied ITER cycles. `alu_op_*`=0 whenever `alu_req`=0.
- **Start handling:**
  - `start` pulsed mid-operation → ignored and the first result is unchanged.
  - `start` in the `done` cycle → second operation begins; its result arrives 33 cycles later.
- **Reset mid-operation:** `RST` at step 10 → `busy`=0, `hi`=`lo`=0, no `done`. A following 2 × 2 → `lo`=4.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the multiply sequencer and the control unit that
// owns the ALU: ALU function encodings, sequencer state encodings, operand
// width, and the operand-magnitude helper.
package mul_sequencer_pkg;

   // Operand width; the sequencer performs exactly this many ALU steps.
   localparam int MUL_WIDTH = 32;

   // ALU function select as seen on alu_control.
   typedef logic [2:0] alu_fn_t;

   localparam alu_fn_t ALU_AND  = 3'b000;
   localparam alu_fn_t ALU_OR   = 3'b001;
   localparam alu_fn_t ALU_ADD  = 3'b010;
   localparam alu_fn_t ALU_SUB  = 3'b011;
   localparam alu_fn_t ALU_ANDN = 3'b100;
   localparam alu_fn_t ALU_ORN  = 3'b101;
   localparam alu_fn_t ALU_SLT  = 3'b110;
   localparam alu_fn_t ALU_XOR  = 3'b111;

   // Sequencer states, kept as plain constants so older control code can
   // compare against them directly.
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_ITER = 2'b01;
   localparam logic [1:0] ST_SIGN = 2'b10;

   // Magnitude of a two's-complement word. The most negative value maps to
   // itself, which is the correct magnitude when read as unsigned.
   function automatic logic [31:0] abs32(input logic [31:0] value);
      return value[31] ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/mul_sequencer.sv
// Multi-cycle 32x32 MULT/MULTU sequencer. Borrows the shared ALU through a
// request/grant handshake and performs one shift-and-add step per granted
// cycle, then fixes the sign of the 64-bit product locally.
module mul_sequencer
   import mul_sequencer_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             alu_req,
   input  logic             alu_gnt,
   output logic [WIDTH-1:0] alu_op_a,
   output logic [WIDTH-1:0] alu_op_b,
   output logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] alu_result
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] m;
   logic             neg;
   logic             carry;
   logic [2*WIDTH-1:0] negated;

   // ALU request and operands are a pure decode of registered state, so the
   // grant never feeds back into the request.
   always_comb begin
      alu_req     = 1'b0;
      alu_op_a    = '0;
      alu_op_b    = '0;
      alu_control = ALU_AND;
      if (state == ST_ITER) begin
         alu_req     = 1'b1;
         alu_op_a    = hi;
         alu_op_b    = lo[0] ? m : '0;
         alu_control = ALU_ADD;
      end
   end

   // Carry out of the ALU addition, rebuilt from the operand and sum sign
   // bits because the shared ALU does not export its carry.
   always_comb begin
      carry = (alu_op_a[WIDTH-1] & alu_op_b[WIDTH-1]) |
              ((alu_op_a[WIDTH-1] | alu_op_b[WIDTH-1]) & ~alu_result[WIDTH-1]);
   end

   // Two's-complement negation of the unsigned product for the SIGN step.
   always_comb begin
      negated = ~{hi, lo} + {{(2*WIDTH-1){1'b0}}, 1'b1};
   end

   // Sequencer state, accumulator and handshake flags.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         count <= '0;
         m     <= '0;
         neg   <= 1'b0;
      end else begin
         // NOTE: all state here uses non-blocking assignments so every branch
         // reads the pre-edge hi/lo/count values, matching the
         // combinational ALU path that was computed from them.
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  m     <= is_signed ? abs32(src_a) : src_a;
                  lo    <= is_signed ? abs32(src_b) : src_b;
                  hi    <= '0;
                  count <= '0;
                  neg   <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  busy  <= 1'b1;
                  state <= ST_ITER;
               end
            end
            ST_ITER: begin
               // Without a grant the ALU result belongs to someone else, so
               // nothing advances.
               if (alu_gnt) begin
                  {hi, lo} <= {carry, alu_result, lo[WIDTH-1:1]};
                  count    <= count + 1'b1;
                  if (count == LAST_STEP) begin
                     state <= ST_SIGN;
                  end
               end
            end
            ST_SIGN: begin
               if (neg) begin
                  {hi, lo} <= negated;
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: stimulus pushes the hand-computed
// product and the cycle on which done must appear; a monitor pops and
// compares on every done pulse. A small ALU model closes the ALU loop.
module tb_mul_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        alu_req;
   logic        alu_gnt = 1'b1;
   logic [31:0] alu_op_a;
   logic [31:0] alu_op_b;
   logic [2:0]  alu_control;
   logic [31:0] alu_result;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic alt = 1'b0;
   logic chk_ops = 1'b0;

   mul_sequencer dut (
      .CLK        (CLK),
      .RST        (RST),
      .start      (start),
      .is_signed  (is_signed),
      .src_a      (src_a),
      .src_b      (src_b),
      .busy       (busy),
      .done       (done),
      .hi         (hi),
      .lo         (lo),
      .alu_req    (alu_req),
      .alu_gnt    (alu_gnt),
      .alu_op_a   (alu_op_a),
      .alu_op_b   (alu_op_b),
      .alu_control(alu_control),
      .alu_result (alu_result)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Reference ALU shared with the datapath owner.
   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] ctl);
      case (ctl)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b011:  return a - b;
         3'b100:  return a & ~b;
         3'b101:  return a | ~b;
         3'b110:  return {31'd0, $signed(a) < $signed(b)};
         default: return a ^ b;
      endcase
   endfunction

   assign alu_result = alu_f(alu_op_a, alu_op_b, alu_control);

   // Grant driver: tied high, or toggling every cycle when alt is set.
   always @(posedge CLK) begin
      #1;
      alu_gnt = alt ? ~alu_gnt : 1'b1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse consumes one scoreboard entry.
   always @(negedge CLK) begin
      if (!RST && done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("hi", {32'd0, hi}, {32'd0, e.hi});
            check("lo", {32'd0, lo}, {32'd0, e.lo});
            check("done_cycle", 64'(cyc), 64'(e.due));
            check("busy_at_done", {63'd0, busy}, 64'd0);
         end
      end
      if (chk_ops && !alu_req) begin
         check("idle_ops", {alu_op_a, alu_op_b}, 64'd0);
         check("idle_ctl", {61'd0, alu_control}, 64'd0);
      end
   end

   // Drive one start pulse; caller is positioned at a negedge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int lat, input logic push);
      exp_t e;
      start     = 1'b1;
      src_a     = a;
      src_b     = b;
      is_signed = sgn;
      if (push) begin
         e.hi  = eh;
         e.lo  = el;
         e.due = cyc + 1 + lat;
         q.push_back(e);
      end
      @(negedge CLK);
      start = 1'b0;
      src_a = $urandom;
      src_b = $urandom;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while ((busy || q.size() != 0) && n < 300);
      if (n >= 300) check("timeout_idle", 64'd1, 64'd0);
   endtask

   initial begin
      int  n;
      logic seen;

      // Reset state, including the combinational ALU outputs.
      repeat (2) @(negedge CLK);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      check("rst_req", {63'd0, alu_req}, 64'd0);
      check("rst_ops", {alu_op_a, alu_op_b}, 64'd0);
      check("rst_ctl", {61'd0, alu_control}, 64'd0);
      RST = 1'b0;
      @(negedge CLK);

      // MULTU small and carry path.
      issue(32'd3, 32'd5, 1'b0, 32'h0, 32'h0000000F, 33, 1'b1);
      check("busy_after_start", {63'd0, busy}, 64'd1);
      check("req_in_iter", {63'd0, alu_req}, 64'd1);
      wait_idle();
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 33, 1'b1);
      wait_idle();

      // MULT signs.
      issue(32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 33, 1'b1);
      wait_idle();
      issue(32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 33, 1'b1);
      wait_idle();
      issue(32'd6, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFD6, 33, 1'b1);
      wait_idle();

      // Grant stalls: first ITER cycle denied, then alternating -> 32 stalls.
      chk_ops = 1'b1;
      alt     = 1'b1;
      issue(32'd7, 32'd9, 1'b0, 32'h0, 32'h0000003F, 65, 1'b1);
      wait_idle();
      alt = 1'b0;
      repeat (3) @(negedge CLK);
      chk_ops = 1'b0;

      // Start pulsed mid-operation is ignored.
      issue(32'h00001234, 32'h00000010, 1'b0, 32'h0, 32'h00012340, 33, 1'b1);
      repeat (5) @(negedge CLK);
      issue(32'hDEADBEEF, 32'h00000003, 1'b1, 32'h0, 32'h0, 0, 1'b0);
      wait_idle();

      // Start in the done cycle begins the next operation at once.
      issue(32'd11, 32'd13, 1'b0, 32'h0, 32'd143, 33, 1'b1);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!done && n < 100);
      if (n >= 100) check("timeout_done", 64'd1, 64'd0);
      issue(32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 32'h0, 33, 1'b1);
      wait_idle();

      // Reset after ten steps: everything clears and no done follows.
      issue(32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'h0, 32'h0, 0, 1'b0);
      repeat (9) @(negedge CLK);
      RST = 1'b1;
      #1;
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      check("mid_rst_hilo", {hi, lo}, 64'd0);
      check("mid_rst_done", {63'd0, done}, 64'd0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge CLK);
         if (done) seen = 1'b1;
      end
      check("no_done_after_rst", {63'd0, seen}, 64'd0);
      issue(32'd2, 32'd2, 1'b0, 32'h0, 32'd4, 33, 1'b1);
      wait_idle();

      check("scoreboard_empty", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
